// File: rtl/raymarch_pkg.sv
// Shared types, constants and fixed-point helpers for the box sphere-tracer.
// Values are signed Q6.20 held in 27 bits.
package raymarch_pkg;

    typedef logic signed [26:0] fixed_t;
    typedef logic [9:0]         color_t;

    localparam int unsigned FRAC      = 20;
    localparam fixed_t      ONE       = 27'sh0100000;
    localparam fixed_t      EPS       = 27'sh0001000;
    localparam fixed_t      T_MAX     = 27'sh1000000;
    localparam int unsigned MAX_STEPS = 32;
    localparam int unsigned FB_W      = 320;
    localparam int unsigned FB_H      = 240;
    localparam color_t      BG_COLOR  = 10'h095;

    typedef enum logic [2:0] {
        StLatch,
        StSetup,
        StEval,
        StStep,
        StWrite
    } state_e;

    // Full 54-bit product, rescaled and truncated back to 27 bits (wraps).
    function automatic fixed_t fmul(input fixed_t a, input fixed_t b);
        logic signed [53:0] prod;
        prod = a * b;
        return 27'(prod >>> FRAC);
    endfunction

endpackage

// File: rtl/raymarch_fb.sv
// Simple dual-port framebuffer: synchronous write, registered read.
// A same-address read and write in one cycle returns the old contents.
module raymarch_fb
    import raymarch_pkg::*;
#(
    parameter int unsigned Depth = FB_W * FB_H,
    parameter int unsigned AddrW = $clog2(FB_W * FB_H)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  color_t           wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output color_t           rdata_o
);

    color_t mem [Depth];
    color_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range reads (re_i low) present black rather than stale data.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/raymarcher.sv
// Sphere-traces a unit Chebyshev box into the framebuffer, one pixel at a time,
// and serves the display scan at 2x downscale through a registered read port.
module raymarcher
    import raymarch_pkg::*;
#(
    parameter int unsigned FbW = FB_W,
    parameter int unsigned FbH = FB_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [26:0] eye_x,
    input  logic signed [26:0] eye_y,
    input  logic signed [26:0] eye_z,
    input  logic signed [26:0] look_at_1_1,
    input  logic signed [26:0] look_at_1_2,
    input  logic signed [26:0] look_at_1_3,
    input  logic signed [26:0] look_at_2_1,
    input  logic signed [26:0] look_at_2_2,
    input  logic signed [26:0] look_at_2_3,
    input  logic signed [26:0] look_at_3_1,
    input  logic signed [26:0] look_at_3_2,
    input  logic signed [26:0] look_at_3_3,
    input  logic [9:0]         read_pixel_x,
    input  logic [9:0]         read_pixel_y,
    output logic [9:0]         o_color,
    output logic               frame_done
);

    localparam int unsigned XW    = $clog2(FbW);
    localparam int unsigned YW    = $clog2(FbH);
    localparam int unsigned AddrW = $clog2(FbW * FbH);

    state_e            state_q, state_d;
    logic [XW-1:0]     px_q, px_d;
    logic [YW-1:0]     py_q, py_d;
    logic [AddrW-1:0]  waddr_q, waddr_d;
    logic [5:0]        steps_q, steps_d;
    logic              hit_q, hit_d;
    logic              done_q, done_d;

    fixed_t eye_q [3];
    fixed_t eye_d [3];
    fixed_t m_q   [9];
    fixed_t m_d   [9];
    fixed_t p_q   [3];
    fixed_t p_d   [3];
    fixed_t dir_q [3];
    fixed_t dir_d [3];
    fixed_t t_q, t_d;

    fixed_t           u, v, sdf, h;
    fixed_t           ax [3];
    logic [3:0]       quarter;
    logic [2:0]       shade;
    color_t           wdata;
    logic             last_px;
    logic             fb_we, fb_re;
    logic [AddrW-1:0] raddr;

    // Chebyshev distance from the current point to the unit box surface.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ax[i] = p_q[i][26] ? -p_q[i] : p_q[i];
        end
        sdf = ax[0];
        if (ax[1] > sdf) sdf = ax[1];
        if (ax[2] > sdf) sdf = ax[2];
        sdf = sdf - ONE;
        h   = sdf >>> 1;
    end

    // Screen-plane coordinates, centred on the framebuffer, 1/256 per pixel.
    always_comb begin
        u = 27'((int'(px_q) - int'(FbW / 2)) * 4096);
        v = 27'((int'(FbH / 2) - int'(py_q)) * 4096);
    end

    always_comb begin
        quarter = steps_q[5:2];
        shade   = (quarter >= 4'd7) ? 3'd0 : 3'd7 - quarter[2:0];
        wdata   = hit_q ? {shade, shade, shade[2], shade} : BG_COLOR;
        last_px = (px_q == XW'(FbW - 1)) && (py_q == YW'(FbH - 1));
    end

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        waddr_d = waddr_q;
        steps_d = steps_q;
        hit_d   = hit_q;
        done_d  = 1'b0;
        eye_d   = eye_q;
        m_d     = m_q;
        p_d     = p_q;
        dir_d   = dir_q;
        t_d     = t_q;

        unique case (state_q)
            StLatch: begin
                eye_d[0] = eye_x;
                eye_d[1] = eye_y;
                eye_d[2] = eye_z;
                m_d[0]   = look_at_1_1;
                m_d[1]   = look_at_1_2;
                m_d[2]   = look_at_1_3;
                m_d[3]   = look_at_2_1;
                m_d[4]   = look_at_2_2;
                m_d[5]   = look_at_2_3;
                m_d[6]   = look_at_3_1;
                m_d[7]   = look_at_3_2;
                m_d[8]   = look_at_3_3;
                state_d  = StSetup;
            end
            StSetup: begin
                for (int i = 0; i < 3; i++) begin
                    dir_d[i] = fmul(m_q[3*i], u) + fmul(m_q[3*i+1], v) + m_q[3*i+2];
                    p_d[i]   = eye_q[i];
                end
                t_d     = '0;
                steps_d = '0;
                state_d = StEval;
            end
            StEval: begin
                if (sdf < EPS) begin
                    hit_d   = 1'b1;
                    state_d = StWrite;
                end else if (steps_q == 6'(MAX_STEPS) || t_q > T_MAX) begin
                    hit_d   = 1'b0;
                    state_d = StWrite;
                end else begin
                    state_d = StStep;
                end
            end
            StStep: begin
                for (int i = 0; i < 3; i++) begin
                    p_d[i] = p_q[i] + fmul(dir_q[i], h);
                end
                t_d     = t_q + h;
                steps_d = steps_q + 6'd1;
                state_d = StEval;
            end
            StWrite: begin
                if (last_px) begin
                    px_d    = '0;
                    py_d    = '0;
                    waddr_d = '0;
                    done_d  = 1'b1;
                    state_d = StLatch;
                end else begin
                    if (px_q == XW'(FbW - 1)) begin
                        px_d = '0;
                        py_d = py_q + YW'(1);
                    end else begin
                        px_d = px_q + XW'(1);
                    end
                    waddr_d = waddr_q + AddrW'(1);
                    state_d = StSetup;
                end
            end
            default: state_d = StLatch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StLatch;
            px_q    <= '0;
            py_q    <= '0;
            waddr_q <= '0;
            steps_q <= '0;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            waddr_q <= waddr_d;
            steps_q <= steps_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        eye_q <= eye_d;
        m_q   <= m_d;
        p_q   <= p_d;
        dir_q <= dir_d;
        t_q   <= t_d;
    end

    // Reset at the write edge drops the in-flight pixel.
    always_comb begin
        fb_we = (state_q == StWrite) && reset;
        fb_re = (read_pixel_x < 10'(2 * FbW)) && (read_pixel_y < 10'(2 * FbH));
        raddr = AddrW'(int'(read_pixel_y >> 1) * int'(FbW) + int'(read_pixel_x >> 1));
    end

    raymarch_fb #(
        .Depth (FbW * FbH),
        .AddrW (AddrW)
    ) u_fb (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (fb_we),
        .waddr_i (waddr_q),
        .wdata_i (wdata),
        .re_i    (fb_re),
        .raddr_i (raddr),
        .rdata_o (o_color)
    );

    assign frame_done = done_q;

endmodule

// File: tb/tb_raymarcher.sv
// Directed bench for raymarcher on a reduced 16x12 framebuffer: read scoreboard against
// an independent sphere-tracing model, plus frame-period and reset checks.
module tb_raymarcher;
    import raymarch_pkg::*;

    localparam int unsigned W = 16;
    localparam int unsigned H = 12;
    localparam int unsigned N = W * H;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [26:0] eye_x, eye_y, eye_z;
    logic signed [26:0] look_at_1_1, look_at_1_2, look_at_1_3;
    logic signed [26:0] look_at_2_1, look_at_2_2, look_at_2_3;
    logic signed [26:0] look_at_3_1, look_at_3_2, look_at_3_3;
    logic [9:0]         read_pixel_x, read_pixel_y;
    logic [9:0]         o_color;
    logic               frame_done;

    int          total = 0;
    int          bad   = 0;
    longint      cyc   = 0;
    longint      pulses [$];
    logic [9:0]  exp_q  [$];
    fixed_t      cam_e [3];
    fixed_t      cam_m [9];
    logic [9:0]  col_a [N];
    logic [9:0]  col_b [N];
    longint      per_a, per_b, t0;
    int          n;

    raymarcher #(
        .FbW (W),
        .FbH (H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .eye_x        (eye_x),
        .eye_y        (eye_y),
        .eye_z        (eye_z),
        .look_at_1_1  (look_at_1_1),
        .look_at_1_2  (look_at_1_2),
        .look_at_1_3  (look_at_1_3),
        .look_at_2_1  (look_at_2_1),
        .look_at_2_2  (look_at_2_2),
        .look_at_2_3  (look_at_2_3),
        .look_at_3_1  (look_at_3_1),
        .look_at_3_2  (look_at_3_2),
        .look_at_3_3  (look_at_3_3),
        .read_pixel_x (read_pixel_x),
        .read_pixel_y (read_pixel_y),
        .o_color      (o_color),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (frame_done === 1'b1) pulses.push_back(cyc);

    function automatic fixed_t mulq(input fixed_t a, input fixed_t b);
        longint pr;
        pr = longint'(a) * longint'(b);
        return 27'(pr >>> 20);
    endfunction

    function automatic fixed_t absq(input fixed_t a);
        return (a < 0) ? -a : a;
    endfunction

    // Reference march for one pixel: returns step count and hit flag.
    task automatic march(input int px, input int py, output int steps, output bit hit);
        fixed_t u, v, t, sdf, h, mx;
        fixed_t d [3];
        fixed_t p [3];
        u = 27'((px - int'(W / 2)) * 4096);
        v = 27'((int'(H / 2) - py) * 4096);
        for (int i = 0; i < 3; i++) begin
            d[i] = mulq(cam_m[3*i], u) + mulq(cam_m[3*i+1], v) + cam_m[3*i+2];
            p[i] = cam_e[i];
        end
        t = '0;
        steps = 0;
        hit = 1'b0;
        while (1) begin
            mx = absq(p[0]);
            if (absq(p[1]) > mx) mx = absq(p[1]);
            if (absq(p[2]) > mx) mx = absq(p[2]);
            sdf = mx - 27'sd1048576;
            if (sdf < 27'sd4096) begin
                hit = 1'b1;
                break;
            end
            if (steps == 32 || t > 27'sd16777216) break;
            h = sdf >>> 1;
            for (int i = 0; i < 3; i++) p[i] = p[i] + mulq(d[i], h);
            t = t + h;
            steps++;
        end
    endtask

    task automatic build(output logic [9:0] col [N], output longint period);
        int s, st;
        bit hit;
        logic [2:0] q;
        period = 1;
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                march(x, y, st, hit);
                period += 2 * st + 3;
                s = 7 - ((st / 4 > 7) ? 7 : st / 4);
                q = 3'(s);
                col[y * W + x] = hit ? {q, q, q[2], q} : 10'h095;
            end
        end
    endtask

    task automatic drive_cam();
        eye_x = cam_e[0]; eye_y = cam_e[1]; eye_z = cam_e[2];
        look_at_1_1 = cam_m[0]; look_at_1_2 = cam_m[1]; look_at_1_3 = cam_m[2];
        look_at_2_1 = cam_m[3]; look_at_2_2 = cam_m[4]; look_at_2_3 = cam_m[5];
        look_at_3_1 = cam_m[6]; look_at_3_2 = cam_m[7]; look_at_3_3 = cam_m[8];
    endtask

    task automatic check(input string tag, input longint obs, input longint want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic rd(input int x, input int y, input logic [9:0] want);
        logic [9:0] e;
        @(posedge clk);
        #1;
        read_pixel_x = 10'(x);
        read_pixel_y = 10'(y);
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("rd(%0d,%0d)", x, y), longint'(o_color), longint'(e));
    endtask

    task automatic wait_pulse(input int idx);
        int guard = 0;
        while (pulses.size() <= idx && guard < 40000) begin
            @(negedge clk);
            guard++;
        end
        total++;
        assert (pulses.size() > idx) else begin
            bad++;
            $error("FAIL frame_done_timeout: observed %0d pulses expected %0d", pulses.size(),
                   idx + 1);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "no frame_done");
        end
    endtask

    initial begin
        reset = 1'b0;
        read_pixel_x = '0;
        read_pixel_y = '0;

        cam_e = '{27'sd0, 27'sd0, -27'sd41943040};
        cam_m = '{27'sd41943040, 27'sd0, 27'sd0,
                  27'sd0, 27'sd41943040, 27'sd0,
                  27'sd0, 27'sd0, 27'sd1048576};
        build(col_b, per_b);
        cam_e = '{27'sd0, 27'sd0, -27'sd4194304};
        build(col_a, per_a);
        drive_cam();

        // Reset held: output port and pulse stay low.
        repeat (5) @(posedge clk);
        rd(W, H, 10'h000);
        check("rst_frame_done", longint'(frame_done), 0);

        @(posedge clk);
        #1;
        reset = 1'b1;
        t0 = cyc;
        wait_pulse(0);
        check("period_first", pulses[0] - t0, per_a);
        @(negedge clk);
        check("pulse_width", longint'(frame_done), 0);

        rd(W, H, 10'h2DD);
        rd(0, 0, 10'h095);
        rd(700, 100, 10'h000);
        rd(100, 500, 10'h000);
        rd(2 * W, 0, 10'h000);
        rd(0, 2 * H, 10'h000);
        for (int y = 0; y < int'(2 * H); y++) begin
            for (int x = 0; x < int'(2 * W); x++) begin
                rd(x, y, col_a[(y / 2) * W + x / 2]);
            end
        end

        // Eye moved mid-frame: this frame keeps the old camera, the next one uses the new.
        n = pulses.size();
        wait_pulse(n);
        repeat (5) @(posedge clk);
        #1;
        cam_e = '{27'sd0, 27'sd0, -27'sd41943040};
        drive_cam();
        wait_pulse(n + 1);
        rd(W, H, 10'h2DD);
        check("period_old_cam", pulses[n + 1] - pulses[n], per_a);
        wait_pulse(n + 2);
        rd(W, H, 10'h095);
        rd(W + 3, H - 2, col_b[((H - 2) / 2) * W + (W + 3) / 2]);
        check("period_new_cam", pulses[n + 2] - pulses[n + 1], per_b);

        // Reset mid-frame, then the restarted frame must run in full.
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b0;
        cam_e = '{27'sd0, 27'sd0, -27'sd4194304};
        drive_cam();
        rd(W, H, 10'h000);
        check("rst_mid_frame_done", longint'(frame_done), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        t0 = cyc;
        n = pulses.size();
        wait_pulse(n);
        check("period_after_reset", pulses[n] - t0, per_a);
        rd(W, H, 10'h2DD);
        rd(1, 1, 10'h095);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
